// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-back arbiter and its scoreboard.
package rf_arb_pkg;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  // Source of the write currently held in the output stage; drives busy-clear.
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU} wb_src_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits and pending count for long-latency ops; produces decode stall and sticky err.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int MAX_PEND = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic                iss_long,
  input  reg_addr_t           iss_rd,
  input  reg_addr_t           iss_rs1,
  input  reg_addr_t           iss_rs2,
  input  logic                lsu_hs,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  output logic                iss_stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [PW-1:0]       pend_q, pend_d;
  logic                err_q, err_d;
  logic                iss_acc;

  always_comb begin
    // busy_q[0] is held at 0, so x0 operands never hit
    iss_stall = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd] ||
                              (iss_long && pend_q == PW'(MAX_PEND)));
    iss_acc   = iss_valid && iss_long && !iss_stall;

    busy_d = busy_q;
    if (clr_en)  busy_d[clr_addr] = 1'b0;
    if (iss_acc) busy_d[iss_rd]   = 1'b1;
    busy_d[0] = 1'b0;

    pend_d = pend_q;
    if (iss_acc && !lsu_hs)                        pend_d = pend_q + 1'b1;
    else if (!iss_acc && lsu_hs && pend_q != '0)   pend_d = pend_q - 1'b1;

    err_d = err_q || (lsu_hs && pend_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign err      = err_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU write-back; ALU has priority.
// Define RF_ARB_STARVE_EN to build the LSU starvation counter and forced grant.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_PEND   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_wb_valid,
  output logic                alu_wb_ready,
  input  reg_addr_t           alu_wb_addr,
  input  xlen_t               alu_wb_data,
  input  logic                lsu_wb_valid,
  output logic                lsu_wb_ready,
  input  reg_addr_t           lsu_wb_addr,
  input  xlen_t               lsu_wb_data,
  input  logic                iss_valid,
  input  logic                iss_long,
  input  reg_addr_t           iss_rd,
  input  reg_addr_t           iss_rs1,
  input  reg_addr_t           iss_rs2,
  output logic                iss_stall,
  output reg_addr_t           rd_addr,
  output xlen_t               rd_data,
  output logic                rd_wen,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);
  logic      forced, alu_gnt, lsu_gnt;
  reg_addr_t rd_addr_q, rd_addr_d;
  xlen_t     rd_data_q, rd_data_d;
  logic      rd_wen_q, rd_wen_d;
  wb_src_t   src_q, src_d;

`ifdef RF_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    forced   = (starve_q == 4'(STARVE_MAX));
    starve_d = (lsu_wb_valid && !lsu_gnt) ? starve_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`else
  // STARVE_MAX has no effect in strict-priority builds.
  logic [3:0] starve_max_unused;
  assign starve_max_unused = 4'(STARVE_MAX);
  assign forced = 1'b0;
`endif

  always_comb begin
    alu_wb_ready = !forced;
    lsu_wb_ready = lsu_wb_valid && (!alu_wb_valid || forced);
    alu_gnt      = alu_wb_valid && alu_wb_ready;
    lsu_gnt      = lsu_wb_valid && lsu_wb_ready;

    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wen_d  = 1'b0;
    src_d     = SRC_NONE;
    // x0 writes complete the handshake but never reach the register file
    if (lsu_gnt) begin
      rd_addr_d = lsu_wb_addr;
      rd_data_d = lsu_wb_data;
      rd_wen_d  = (lsu_wb_addr != '0);
      src_d     = SRC_LSU;
    end else if (alu_gnt) begin
      rd_addr_d = alu_wb_addr;
      rd_data_d = alu_wb_data;
      rd_wen_d  = (alu_wb_addr != '0);
      src_d     = SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wen_q  <= 1'b0;
      src_q     <= SRC_NONE;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_wen_q  <= rd_wen_d;
      src_q     <= src_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign rd_wen  = rd_wen_q;

  rf_scoreboard #(.MAX_PEND(MAX_PEND)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .lsu_hs    (lsu_gnt),
    .clr_en    (rd_wen_q && src_q == SRC_LSU),
    .clr_addr  (rd_addr_q),
    .iss_stall (iss_stall),
    .busy_vec  (busy_vec),
    .err       (err)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed test-plan items, then randomized traffic.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  localparam int MAX_PEND   = 4;
  localparam int STARVE_MAX = 3;
`ifdef RF_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed { reg_addr_t a; xlen_t d; } wr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic alu_wb_valid = 0, alu_wb_ready, lsu_wb_valid = 0, lsu_wb_ready;
  reg_addr_t alu_wb_addr = '0, lsu_wb_addr = '0;
  xlen_t alu_wb_data = '0, lsu_wb_data = '0;
  logic iss_valid = 0, iss_long = 0, iss_stall;
  reg_addr_t iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  reg_addr_t rd_addr;
  xlen_t rd_data;
  logic rd_wen, err;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.MAX_PEND(MAX_PEND), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .iss_valid(iss_valid), .iss_long(iss_long),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
    .busy_vec(busy_vec), .err(err)
  );

  int n_chk = 0, n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: architectural view of the scoreboard and arbitration rules
  bit        m_busy [NUM_REGS];
  int        m_pend = 0, m_starve = 0, m_clr_a = 0;
  bit        m_err = 0, m_clr_v = 0;
  reg_addr_t long_q [$];
  wr_t       exp_q  [$];
  bit        s_alu_rdy, s_lsu_rdy, s_stall, g_alu = 0, g_lsu = 0;
  reg_addr_t drain [4] = '{5'd2, 5'd3, 5'd4, 5'd6};

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit hit(reg_addr_t a);
    return (a != 0) && m_busy[a];
  endfunction

  // One cycle: check combinational outputs at negedge, advance the model, return at posedge+1
  task automatic step();
    bit forced, e_ar, e_lr, e_st, inc;
    @(negedge clk);
    s_alu_rdy = alu_wb_ready;
    s_lsu_rdy = lsu_wb_ready;
    s_stall   = iss_stall;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_pend = 0; m_starve = 0; m_err = 0; m_clr_v = 0;
      long_q.delete();
      g_alu = 0; g_lsu = 0;
    end else begin
      forced = STARVE_EN && (m_starve == STARVE_MAX);
      e_ar = !forced;
      e_lr = lsu_wb_valid && (!alu_wb_valid || forced);
      e_st = iss_valid && (hit(iss_rs1) || hit(iss_rs2) || hit(iss_rd) ||
                           (iss_long && m_pend == MAX_PEND));
      chk("alu_wb_ready", 32'(alu_wb_ready), 32'(e_ar));
      chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(e_lr));
      chk("iss_stall", 32'(iss_stall), 32'(e_st));
      chk("busy_vec", busy_vec, model_busy());
      chk("err", 32'(err), 32'(m_err));
      g_alu = alu_wb_valid && e_ar;
      g_lsu = lsu_wb_valid && e_lr;
      if (g_lsu && lsu_wb_addr != 0) exp_q.push_back('{a: lsu_wb_addr, d: lsu_wb_data});
      else if (g_alu && alu_wb_addr != 0) exp_q.push_back('{a: alu_wb_addr, d: alu_wb_data});
      inc = iss_valid && iss_long && !e_st;
      if (m_clr_v) m_busy[m_clr_a] = 0;
      m_clr_v = g_lsu && lsu_wb_addr != 0;
      m_clr_a = int'(lsu_wb_addr);
      if (inc && iss_rd != 0) m_busy[iss_rd] = 1;
      if (g_lsu && m_pend == 0) m_err = 1;
      if (inc && !g_lsu) m_pend++;
      else if (!inc && g_lsu && m_pend > 0) m_pend--;
      m_starve = (lsu_wb_valid && !g_lsu) ? m_starve + 1 : 0;
      if (inc) long_q.push_back(iss_rd);
      if (g_lsu && long_q.size() > 0) void'(long_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every committed write must match the oldest expected grant
  always @(negedge clk) begin
    wr_t w;
    if (rd_wen === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_wen_unexpected", 32'(rd_wen), 32'd0);
      else begin
        w = exp_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(w.a));
        chk("rd_data", rd_data, w.d);
      end
    end
  end

  task automatic issue(bit lng, reg_addr_t rd, reg_addr_t rs1, reg_addr_t rs2);
    iss_valid = 1; iss_long = lng; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
  endtask

  task automatic lsu(reg_addr_t a, xlen_t d);
    lsu_wb_valid = 1; lsu_wb_addr = a; lsu_wb_data = d;
  endtask

  initial begin
    // Reset
    step(); step();
    rst = 0;
    chk("reset rd_wen", 32'(rd_wen), 32'd0);
    chk("reset rd_addr", 32'(rd_addr), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset busy_vec", busy_vec, 32'd0);
    chk("reset err", 32'(err), 32'd0);

    // ALU write to x5
    alu_wb_valid = 1; alu_wb_addr = 5; alu_wb_data = 32'hDEADBEEF;
    step();
    chk("alu x5 ready", 32'(s_alu_rdy), 32'd1);
    alu_wb_valid = 0;
    chk("alu x5 rd_wen", 32'(rd_wen), 32'd1);
    chk("alu x5 rd_addr", 32'(rd_addr), 32'd5);
    chk("alu x5 rd_data", rd_data, 32'hDEADBEEF);

    // ALU/LSU contention for 5 cycles
    issue(1, 9, 0, 0); step(); iss_valid = 0;
    lsu(9, 32'h0000_0099);
    alu_wb_valid = 1; alu_wb_addr = 3;
    for (int k = 0; k < 5; k++) begin
      alu_wb_data = $urandom;
      step();
      chk("contend lsu_ready", 32'(s_lsu_rdy), 32'(STARVE_EN && k == 3));
      chk("contend alu_ready", 32'(s_alu_rdy), 32'(!(STARVE_EN && k == 3)));
      if (g_lsu) lsu_wb_valid = 0;
    end
    alu_wb_valid = 0;
    if (lsu_wb_valid) begin
      step();
      chk("lsu after alu idle", 32'(s_lsu_rdy), 32'd1);
      lsu_wb_valid = 0;
    end

    // RAW on x7 released two cycles after the LSU grant
    issue(1, 7, 0, 0); step();
    issue(0, 10, 7, 0);
    step(); chk("raw x7 stall a", 32'(s_stall), 32'd1);
    step(); chk("raw x7 stall b", 32'(s_stall), 32'd1);
    lsu(7, 32'h0000_0077);
    step(); chk("raw x7 stall N", 32'(s_stall), 32'd1);
    chk("raw x7 lsu grant", 32'(s_lsu_rdy), 32'd1);
    lsu_wb_valid = 0;
    step(); chk("raw x7 stall N+1", 32'(s_stall), 32'd1);
    step(); chk("raw x7 stall N+2", 32'(s_stall), 32'd0);
    iss_valid = 0;

    // Pending limit
    for (int i = 1; i <= 4; i++) begin
      issue(1, 5'(i), 0, 0); step();
      chk("pend fill stall", 32'(s_stall), 32'd0);
    end
    issue(1, 6, 0, 0);
    step(); chk("pend full stall", 32'(s_stall), 32'd1);
    lsu(1, 32'h1111_1111);
    step(); chk("pend full stall N", 32'(s_stall), 32'd1);
    lsu_wb_valid = 0;
    step(); chk("pend release", 32'(s_stall), 32'd0);
    iss_valid = 0;
    for (int i = 0; i < 4; i++) begin
      lsu(drain[i], $urandom); step(); lsu_wb_valid = 0;
    end

    // x0 write from LSU, then underflow sets sticky err
    issue(1, 0, 0, 0); step(); iss_valid = 0;
    lsu(0, 32'h0000_1234);
    step(); chk("x0 lsu ready", 32'(s_lsu_rdy), 32'd1);
    lsu_wb_valid = 0;
    chk("x0 rd_wen", 32'(rd_wen), 32'd0);
    step();
    lsu(5, 32'h5555_0000);
    step(); lsu_wb_valid = 0;
    chk("err set", 32'(err), 32'd1);
    step(); step(); step();
    chk("err sticky", 32'(err), 32'd1);

    // Reset right after an LSU grant
    issue(1, 12, 0, 0); step();
    issue(1, 13, 0, 0); step(); iss_valid = 0;
    lsu(12, 32'hC0C0_1212);
    step(); lsu_wb_valid = 0;
    rst = 1; step(); rst = 0;
    chk("mid reset rd_wen", 32'(rd_wen), 32'd0);
    chk("mid reset busy_vec", busy_vec, 32'd0);
    chk("mid reset err", 32'(err), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!alu_wb_valid || g_alu) begin
        alu_wb_valid = 1'($urandom_range(0, 1));
        alu_wb_addr  = 5'($urandom);
        alu_wb_data  = $urandom;
      end
      if (!lsu_wb_valid || g_lsu) begin
        if (long_q.size() > 0 && $urandom_range(0, 2) == 0) lsu(long_q[0], $urandom);
        else lsu_wb_valid = 0;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      step();
    end
    alu_wb_valid = 0; lsu_wb_valid = 0; iss_valid = 0;
    step(); step(); step();
    chk("expected writes drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
